mul8su_seq_ctrl: RTL



---
 rtl/mul8su_seq_ctrl_pkg.sv | 39 +++
 rtl/mul8su_seq_ctrl_if.sv | 28 ++
 rtl/mul8su_seq_ctrl_core.sv | 23 ++
 rtl/mul8su_seq_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/mul8su_seq_ctrl_pkg.sv
// mul8su_pkg: shared types and constants for the sequential 8x8
// signed-by-unsigned multiplier controller.
//   state_t    - controller FSM states (IDLE, MUL, DONE)
//   step_t     - 2-bit step index; LAST_STEP marks the final step
//   ACC_W      - accumulator / result width
//   CORE_PP_W  - width of the 5x4 core's signed partial product
//   step_shift - left shift applied to each step's partial product
package mul8su_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

  localparam step_t LAST_STEP = 2'd3;
  localparam int    ACC_W     = 16;
  localparam int    CORE_PP_W = 9;

  localparam logic [3:0] SHIFT_STEP0 = 4'd0;
  localparam logic [3:0] SHIFT_STEP1 = 4'd4;
  localparam logic [3:0] SHIFT_STEP2 = 4'd4;
  localparam logic [3:0] SHIFT_STEP3 = 4'd8;

  // Nibble weights: lo*lo -> 0, lo*hi and hi*lo -> 4, hi*hi -> 8.
  function automatic logic [3:0] step_shift(step_t step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = SHIFT_STEP0;
      2'd1:    sh = SHIFT_STEP1;
      2'd2:    sh = SHIFT_STEP2;
      default: sh = SHIFT_STEP3;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mul8su_seq_ctrl_if.sv
// mul8su_seq_ctrl_if: operand and result handshakes of the multiplier.
//   in_valid/in_ready/s/u      - operand channel (s signed, u unsigned)
//   out_valid/out_ready/out    - result channel (16-bit signed product)
//   busy                       - operation in progress or result pending
// master: producer/consumer side; slave: the multiplier controller.
interface mul8su_seq_ctrl_if;
  import mul8su_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       s;
  logic [7:0]       u;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out;
  logic             busy;

  modport master (
    output in_valid, s, u, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, s, u, out_ready,
    output in_ready, out_valid, out, busy
  );

endinterface

// File: rtl/mul8su_seq_ctrl_core.sv
// mul4_su_core: combinational 5-bit signed x 4-bit unsigned multiplier.
//   s5 - signed multiplicand slice (low nibble zero-extended or
//        high nibble sign-extended by the caller)
//   u4 - unsigned multiplier nibble
//   pp - 9-bit signed product, range [-240, 225]
module mul4_su_core
  import mul8su_pkg::*;
(
  input  logic signed [4:0]           s5,
  input  logic        [3:0]           u4,
  output logic signed [CORE_PP_W-1:0] pp
);

  logic signed [CORE_PP_W-1:0] s_ext;
  logic signed [CORE_PP_W-1:0] u_ext;

  // Both operands widened to the product width; the true product always
  // fits in 9 bits, so a modulo-2^9 multiply is exact.
  assign s_ext = {{(CORE_PP_W-5){s5[4]}}, s5};
  assign u_ext = {{(CORE_PP_W-4){1'b0}}, u4};
  assign pp    = s_ext * u_ext;

endmodule

// File: rtl/mul8su_seq_ctrl.sv
// mul8su_seq_ctrl: sequential 8x8 signed-by-unsigned multiplier. One
// 5x4 core is time-shared over four steps; shifted partial products are
// summed into a 16-bit two's-complement accumulator.
//   clk, rst   - clock and synchronous active-high reset
//   bus        - operand/result handshakes (see mul8su_seq_ctrl_if)
//   EARLY_ZERO - when 1, a zero operand finishes after one step with 0
//
// state | meaning
// IDLE  | ready for an operand pair (in_ready = 1)
// MUL   | one partial product accumulated per cycle, steps 0..3
// DONE  | result presented (out_valid = 1) until out_ready
module mul8su_seq_ctrl
  import mul8su_pkg::*;
#(
  parameter bit EARLY_ZERO = 1'b1
) (
  input logic               clk,
  input logic               rst,
  mul8su_seq_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  step_t            step_q, step_d;
  logic [7:0]       s_q, s_d;
  logic [7:0]       u_q, u_d;
  logic             zero_q, zero_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic signed [4:0]           core_s5;
  logic        [3:0]           core_u4;
  logic signed [CORE_PP_W-1:0] core_pp;
  logic        [ACC_W-1:0]     pp_ext;
  logic        [ACC_W-1:0]     pp_shifted;

  // step[1] selects the signed high nibble of s, step[0] the high nibble of u.
  assign core_s5 = step_q[1] ? {s_q[7], s_q[7:4]} : {1'b0, s_q[3:0]};
  assign core_u4 = step_q[0] ? u_q[7:4] : u_q[3:0];

  mul4_su_core u_core (
    .s5 (core_s5),
    .u4 (core_u4),
    .pp (core_pp)
  );

  assign pp_ext     = {{(ACC_W-CORE_PP_W){core_pp[CORE_PP_W-1]}}, core_pp};
  assign pp_shifted = pp_ext << step_shift(step_q);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    s_d     = s_q;
    u_d     = u_q;
    zero_d  = zero_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.s;
          u_d     = bus.u;
          zero_d  = (bus.s == 8'd0) || (bus.u == 8'd0);
          acc_d   = '0;
          step_d  = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        // The zero flag is captured at accept so the short path costs one
        // MUL cycle, matching the one-step latency of a zero operand.
        if (EARLY_ZERO && zero_q) begin
          acc_d   = '0;
          state_d = DONE;
        end else begin
          acc_d  = acc_q + pp_shifted;
          step_d = step_q + 2'd1;
          if (step_q == LAST_STEP) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      s_q     <= '0;
      u_q     <= '0;
      zero_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      s_q     <= s_d;
      u_q     <= u_d;
      zero_q  <= zero_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = acc_q;

endmodule
